// File: rtl/issue_sched.sv
// issue_sched: issue-stage scoreboard with hazard stalls and a fixed-latency
// writeback slot pipeline driving the register-file write port.
module issue_sched #(
    parameter int ALU_LAT = 2,
    parameter int LD_LAT  = 4,
    parameter int ST_LAT  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        id_rd_a_en,
    input  logic [4:0]  id_rd_a,
    input  logic        id_rd_b_en,
    input  logic [4:0]  id_rd_b,
    input  logic        id_wr_en,
    input  logic [4:0]  id_wr_addr,
    input  logic        id_mem_en,
    input  logic        id_mem_wr,
    input  logic        flush,
    output logic        id_ready,
    output logic        issue,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic        wb_from_mem,
    output logic        mem_busy,
    output logic [31:0] pend_vec
);
    localparam int D    = LD_LAT;
    localparam int MAXL = (LD_LAT > ST_LAT) ? LD_LAT : ST_LAT;
    localparam int MW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    logic [31:0]       r_pend;
    logic [D-1:0]      r_slot_v;
    logic [D-1:0][4:0] r_slot_a;
    logic [D-1:0]      r_slot_m;
    logic [MW-1:0]     r_memcnt;

    logic              w_is_ld;
    logic              w_wr;
    logic              w_raw;
    logic              w_waw;
    logic              w_port;
    logic              w_mem;
    logic              w_issue_wr;
    logic [D-1:0]      w_nv;
    logic [D-1:0][4:0] w_na;
    logic [D-1:0]      w_nm;
    logic [31:0]       w_clr;
    logic [31:0]       w_set;
    logic [MW-1:0]     w_memcnt;

    // A store never writes a register, whatever id_wr_en says.
    assign w_is_ld    = id_mem_en & ~id_mem_wr;
    assign w_wr       = id_wr_en & ~(id_mem_en & id_mem_wr);
    assign w_raw      = (id_rd_a_en & r_pend[id_rd_a]) | (id_rd_b_en & r_pend[id_rd_b]);
    assign w_waw      = w_wr & r_pend[id_wr_addr];
    // A load lands in slot[D], which is always empty, so only ALU writes can collide.
    assign w_port     = w_wr & ~w_is_ld & r_slot_v[ALU_LAT];
    assign w_mem      = id_mem_en & (r_memcnt != '0);
    assign id_ready   = ~(w_raw | w_waw | w_port | w_mem);
    assign issue      = id_valid & id_ready & ~flush;
    assign w_issue_wr = issue & w_wr;

    always_comb begin
        w_nv = '0;
        w_na = '0;
        w_nm = '0;
        for (int i = 0; i < D - 1; i++) begin
            w_nv[i] = r_slot_v[i+1];
            w_na[i] = r_slot_a[i+1];
            w_nm[i] = r_slot_m[i+1];
        end
        if (w_issue_wr && w_is_ld) begin
            w_nv[D-1] = 1'b1;
            w_na[D-1] = id_wr_addr;
            w_nm[D-1] = 1'b1;
        end else if (w_issue_wr) begin
            w_nv[ALU_LAT-1] = 1'b1;
            w_na[ALU_LAT-1] = id_wr_addr;
            w_nm[ALU_LAT-1] = 1'b0;
        end
    end

    assign w_clr    = r_slot_v[0] ? (32'd1 << r_slot_a[0]) : 32'd0;
    assign w_set    = w_issue_wr ? (32'd1 << id_wr_addr) : 32'd0;
    assign w_memcnt = (issue & id_mem_en) ? (id_mem_wr ? MW'(ST_LAT - 1) : MW'(LD_LAT - 1))
                    : (r_memcnt != '0) ? r_memcnt - 1'b1 : r_memcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend   <= '0;
            r_slot_v <= '0;
            r_slot_a <= '0;
            r_slot_m <= '0;
            r_memcnt <= '0;
        end else if (flush) begin
            r_pend   <= '0;
            r_slot_v <= '0;
            r_slot_a <= '0;
            r_slot_m <= '0;
            r_memcnt <= '0;
        end else begin
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_slot_v <= w_nv;
            r_slot_a <= w_na;
            r_slot_m <= w_nm;
            r_memcnt <= w_memcnt;
        end
    end

    assign wb_en       = r_slot_v[0];
    assign wb_addr     = r_slot_a[0];
    assign wb_from_mem = r_slot_m[0];
    assign mem_busy    = (r_memcnt != '0);
    assign pend_vec    = r_pend;
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: random and directed stimulus checked against an event-list
// model of scheduled writebacks and memory-port free time.
module tb_issue_sched;
    localparam int ALU = 2;
    localparam int LD  = 4;
    localparam int ST  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic        id_rd_a_en = 1'b0;
    logic [4:0]  id_rd_a = '0;
    logic        id_rd_b_en = 1'b0;
    logic [4:0]  id_rd_b = '0;
    logic        id_wr_en = 1'b0;
    logic [4:0]  id_wr_addr = '0;
    logic        id_mem_en = 1'b0;
    logic        id_mem_wr = 1'b0;
    logic        flush = 1'b0;
    logic        id_ready;
    logic        issue;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic        wb_from_mem;
    logic        mem_busy;
    logic [31:0] pend_vec;

    issue_sched #(.ALU_LAT(ALU), .LD_LAT(LD), .ST_LAT(ST)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rd_a_en(id_rd_a_en), .id_rd_a(id_rd_a),
        .id_rd_b_en(id_rd_b_en), .id_rd_b(id_rd_b),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_mem_en(id_mem_en), .id_mem_wr(id_mem_wr), .flush(flush),
        .id_ready(id_ready), .issue(issue), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_from_mem(wb_from_mem), .mem_busy(mem_busy), .pend_vec(pend_vec)
    );

    always #5 clk = ~clk;

    typedef struct {int w; logic [4:0] a; logic m;} ev_t;
    ev_t evq[$];
    int  cyc = 0;
    int  mem_free = 0;
    int  checks = 0;
    int  failures = 0;
    logic m_iss;
    int  iss_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Called at negedge+1 with inputs driven; checks this cycle, advances the model.
    task automatic step();
        logic [31:0] pm;
        logic ewb, em, ld, wr, port, rdy;
        logic [4:0] ea;
        int lat;
        #1;
        pm = '0; ewb = 0; ea = '0; em = 0; port = 0;
        ld  = id_mem_en & ~id_mem_wr;
        wr  = id_wr_en & ~(id_mem_en & id_mem_wr);
        lat = ld ? LD : ALU;
        foreach (evq[i]) begin
            pm[evq[i].a] = 1'b1;
            if (evq[i].w == cyc) begin ewb = 1; ea = evq[i].a; em = evq[i].m; end
            if (wr && evq[i].w == cyc + lat) port = 1;
        end
        rdy = !((id_rd_a_en && pm[id_rd_a]) || (id_rd_b_en && pm[id_rd_b]) ||
                (wr && pm[id_wr_addr]) || port || (id_mem_en && cyc < mem_free));
        m_iss = id_valid && rdy && !flush;
        check("id_ready", 32'(id_ready), 32'(rdy));
        check("issue", 32'(issue), 32'(m_iss));
        check("wb_en", 32'(wb_en), 32'(ewb));
        if (ewb) begin
            check("wb_addr", 32'(wb_addr), 32'(ea));
            check("wb_from_mem", 32'(wb_from_mem), 32'(em));
        end
        check("mem_busy", 32'(mem_busy), 32'(cyc < mem_free));
        check("pend_vec", pend_vec, pm);
        for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].w <= cyc) evq.delete(i);
        if (flush) begin
            evq.delete();
            mem_free = cyc + 1;
        end else if (m_iss) begin
            iss_cyc = cyc;
            if (wr) evq.push_back('{cyc + lat, id_wr_addr, ld});
            if (id_mem_en) mem_free = cyc + (id_mem_wr ? ST : LD);
        end
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic present(input logic ra_en, input logic [4:0] ra, input logic rb_en,
                           input logic [4:0] rb, input logic we, input logic [4:0] wa,
                           input logic me, input logic mw);
        int n;
        id_valid = 1; id_rd_a_en = ra_en; id_rd_a = ra; id_rd_b_en = rb_en; id_rd_b = rb;
        id_wr_en = we; id_wr_addr = wa; id_mem_en = me; id_mem_wr = mw;
        n = 0;
        do begin step(); n++; end while (!m_iss && n < 20);
        if (!m_iss) check("present_timeout", 0, 1);
        id_valid = 0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        id_valid = 0; flush = 0;
        #1 reset = 1;
        #1;
        check("rst_pend", pend_vec, 32'h0);
        check("rst_wb_en", 32'(wb_en), 32'h0);
        check("rst_mem_busy", 32'(mem_busy), 32'h0);
        check("rst_id_ready", 32'(id_ready), 32'h1);
        #1 reset = 0;
        evq.delete();
        mem_free = 0;
        cyc++;
        @(negedge clk);
        #1;
    endtask

    int t0;
    initial begin
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        check("init_wb_addr", 32'(wb_addr), 32'h0);
        check("init_wb_mem", 32'(wb_from_mem), 32'h0);
        idle(2);
        // Reset with r3 (load) and r5 (ALU) in flight.
        present(0, 0, 0, 0, 1, 3, 1, 0);
        present(0, 0, 0, 0, 1, 5, 0, 0);
        check("pend_before_rst", pend_vec, 32'h28);
        pulse_reset();
        idle(2);
        // RAW on port B: writer at 0, reader issues at 3.
        t0 = cyc;
        present(0, 0, 0, 0, 1, 5, 0, 0);
        present(0, 0, 1, 5, 0, 0, 0, 0);
        check("raw_issue_cyc", 32'(iss_cyc - t0), 32'd3);
        idle(6);
        // Write-port conflict: r7 presented at 2 issues at 3.
        t0 = cyc;
        present(0, 0, 0, 0, 1, 3, 1, 0);
        idle(1);
        present(0, 0, 0, 0, 1, 7, 0, 0);
        check("port_issue_cyc", 32'(iss_cyc - t0), 32'd3);
        idle(6);
        // Store behind load waits for the memory port.
        t0 = cyc;
        present(0, 0, 0, 0, 1, 10, 1, 0);
        present(0, 0, 0, 0, 1, 11, 1, 1);
        check("mem_issue_cyc", 32'(iss_cyc - t0), 32'd4);
        idle(6);
        // Flush kills an in-flight load; a new load issues right after.
        t0 = cyc;
        present(0, 0, 0, 0, 1, 9, 1, 0);
        flush = 1; step(); flush = 0;
        check("flush_pend", pend_vec, 32'h0);
        present(0, 0, 0, 0, 1, 12, 1, 0);
        check("flush_reissue_cyc", 32'(iss_cyc - t0), 32'd2);
        idle(6);
        // Back-to-back independent ALU writes.
        t0 = cyc;
        present(0, 0, 0, 0, 1, 1, 0, 0);
        present(0, 0, 0, 0, 1, 2, 0, 0);
        present(0, 0, 0, 0, 1, 4, 0, 0);
        check("b2b_issue_cyc", 32'(iss_cyc - t0), 32'd2);
        idle(6);
        // Random traffic; the decoder holds a stalled instruction.
        for (int n = 0; n < 3000; n++) begin
            int k;
            if (n % 700 == 699) pulse_reset();
            if (!(id_valid && !m_iss)) begin
                k = $urandom_range(0, 9);
                id_valid   = ($urandom % 5) != 0;
                id_rd_a_en = $urandom % 2;
                id_rd_b_en = $urandom % 2;
                id_rd_a    = 5'($urandom_range(0, 7));
                id_rd_b    = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                id_wr_addr = ($urandom % 8 == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                id_mem_en  = (k < 3);
                id_mem_wr  = (k == 2);
                id_wr_en   = (k < 2) ? 1'b1 : (k == 2) ? 1'b0 : (($urandom % 4) != 0);
            end
            flush = ($urandom % 30) == 0;
            step();
        end
        flush = 0;
        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
